serial_link_apb_cfg_completer: RTL

//   APB completer for the serial-link control/status registers; the far end of the APB driver that configures a link.

---
 rtl/serial_link_apb_cfg_completer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/serial_link_apb_cfg_completer.sv
// serial_link_apb_cfg_completer
//   APB completer for the serial-link control/status registers.
//   0x0 CTRL     RW  bit0 clk_ena, bit1 link_rst_n, bit8 axi_in_isolate, bit9 axi_out_isolate
//   0x4 ISOLATED RO  {30'b0, axi_out_isolated, axi_in_isolated}, 2-flop synchronised
//   Optional feature macro: SERIAL_LINK_CFG_ERR_EN (error responses on unmapped
//   addresses and writes to ISOLATED); when undefined pslverr_o is tied low.
//   APB handshake: a transfer starts with a SETUP cycle (psel_i & ~penable_i),
//   continues through ACCESS cycles (psel_i & penable_i) and completes in the
//   single cycle where pready_o=1; the master must hold psel_i, penable_i,
//   paddr_i, pwrite_i, pwdata_i and pstrb_i stable until then. Dropping psel_i
//   before pready_o aborts the transfer without any register update.
module serial_link_apb_cfg_completer #(
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned WaitCycles = 0,
   parameter logic [31:0] CtrlRstVal = 32'h0000_0300
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   psel_i,
   input  logic                   penable_i,
   input  logic                   pwrite_i,
   input  logic [AddrWidth-1:0]   paddr_i,
   input  logic [DataWidth-1:0]   pwdata_i,
   input  logic [DataWidth/8-1:0] pstrb_i,
   output logic [DataWidth-1:0]   prdata_o,
   output logic                   pready_o,
   output logic                   pslverr_o,
   output logic                   clk_ena_o,
   output logic                   link_rst_no,
   output logic                   axi_in_isolate_o,
   output logic                   axi_out_isolate_o,
   input  logic                   axi_in_isolated_i,
   input  logic                   axi_out_isolated_i,
   output logic [1:0]             dbg_state_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam logic [DataWidth-1:0] CtrlMask = DataWidth'(32'h0000_0303);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q;
   logic [AddrWidth-1:2]   addr_q;
   logic                   write_q;
   logic [DataWidth-1:0]   wdata_q;
   logic [StrbWidth-1:0]   strb_q;
   logic [DataWidth-1:0]   ctrl_q;
   logic [1:0]             iso_meta_q, iso_sync_q;

   logic                   setup;
   logic                   xfer_done;
   logic                   addr_hi;
   logic                   sel_ctrl;
   logic                   sel_iso;
   logic                   err;
   logic                   commit;
   logic [DataWidth-1:0]   byte_mask;
   logic [DataWidth-1:0]   ctrl_d;
   logic [DataWidth-1:0]   rdata;
   logic                   unused_addr;

   // Byte offset bits carry no meaning for word registers.
   assign unused_addr = ^paddr_i[1:0];

   assign setup     = psel_i & ~penable_i;
   assign xfer_done = (state_q == ST_RESP) & psel_i & penable_i;

   // Address decode on the latched word index; anything beyond word 1 is unmapped.
   assign addr_hi  = |addr_q[AddrWidth-1:3];
   assign sel_ctrl = ~addr_hi & ~addr_q[2];
   assign sel_iso  = ~addr_hi &  addr_q[2];
`ifdef SERIAL_LINK_CFG_ERR_EN
   assign err = addr_hi | (write_q & sel_iso);
`else
   assign err = 1'b0;
`endif
   assign commit = xfer_done & write_q & sel_ctrl & ~err;

   // Expand byte strobes into a bit mask and merge write data into CTRL.
   always_comb begin
      byte_mask = '0;
      for (int k = 0; k < StrbWidth; k++) begin
         byte_mask[8*k +: 8] = {8{strb_q[k]}};
      end
      ctrl_d = ((ctrl_q & ~byte_mask) | (wdata_q & byte_mask)) & CtrlMask;
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // FSM next-state logic: SETUP -> (ACCESS wait) -> RESP -> IDLE, abort on psel drop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (setup) state_d = (WaitCycles == 0) ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!psel_i)                           state_d = ST_IDLE;
            else if (penable_i && cnt_q == 4'd1)   state_d = ST_RESP;
         end
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Wait counter: loaded on SETUP, decremented on each ACCESS cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (state_q == ST_IDLE && setup) begin
         cnt_q <= 4'(WaitCycles);
      end else if (state_q == ST_ACCESS && psel_i && penable_i && cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Capture the request attributes in the SETUP cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (state_q == ST_IDLE && setup) begin
         addr_q  <= paddr_i[AddrWidth-1:2];
         write_q <= pwrite_i;
         wdata_q <= pwdata_i;
         strb_q  <= pstrb_i;
      end
   end

   // CTRL register: updated only in the completing cycle of a legal write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     ctrl_q <= DataWidth'(CtrlRstVal) & CtrlMask;
      else if (commit) ctrl_q <= ctrl_d;
   end

   // Two-flop synchronisers for the isolation status; reset to "isolated".
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iso_meta_q <= 2'b11;
         iso_sync_q <= 2'b11;
      end else begin
         iso_meta_q <= {axi_out_isolated_i, axi_in_isolated_i};
         iso_sync_q <= iso_meta_q;
      end
   end

   // Output logic: response signals exist only in the completing cycle.
   always_comb begin
      rdata = '0;
      if (sel_ctrl)     rdata = ctrl_q;
      else if (sel_iso) rdata = {{(DataWidth-2){1'b0}}, iso_sync_q};
      pready_o  = xfer_done;
      pslverr_o = xfer_done & err;
      prdata_o  = (xfer_done && !write_q && !err) ? rdata : '0;
   end

   assign clk_ena_o         = ctrl_q[0];
   assign link_rst_no       = ctrl_q[1];
   assign axi_in_isolate_o  = ctrl_q[8];
   assign axi_out_isolate_o = ctrl_q[9];
   assign dbg_state_o       = state_q;

endmodule
